// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, square helpers and pawn start ranks.
package chess_pkg;

   // Piece type codes as presented on the request bus and to the array
   localparam logic [3:0] BROOK   = 4'd0;
   localparam logic [3:0] BKNIGHT = 4'd1;
   localparam logic [3:0] BBISHOP = 4'd2;
   localparam logic [3:0] BQUEEN  = 4'd3;
   localparam logic [3:0] BKING   = 4'd4;
   localparam logic [3:0] BPAWN   = 4'd5;
   localparam logic [3:0] WROOK   = 4'd6;
   localparam logic [3:0] WKNIGHT = 4'd7;
   localparam logic [3:0] WBISHOP = 4'd8;
   localparam logic [3:0] WQUEEN  = 4'd9;
   localparam logic [3:0] WKING   = 4'd10;
   localparam logic [3:0] WPAWN   = 4'd11;

   // Ranks from which a pawn may advance two squares
   localparam logic [2:0] WHITE_PAWN_RANK = 3'd1;
   localparam logic [2:0] BLACK_PAWN_RANK = 3'd6;

   // Square id = rank*8 + file
   function automatic logic [2:0] rank(input logic [5:0] s);
      return s[5:3];
   endfunction

   function automatic logic [2:0] file(input logic [5:0] s);
      return s[2:0];
   endfunction

endpackage

// File: rtl/lsb_finder64.sv
// Lowest-set-bit priority encoder over a 64-bit vector, with flags telling
// whether any bit is set and whether exactly one bit is set.
module lsb_finder64
   import chess_pkg::*;
(
   input  logic [63:0] vec_i,
   output logic [5:0]  idx_o,
   output logic        one_left_o,
   output logic        any_o
);

   // Scan from the top down so the last hit is the lowest set bit
   always_comb begin
      idx_o = '0;
      for (int i = 63; i >= 0; i--) begin
         if (vec_i[i]) idx_o = 6'(i);
      end
   end

   // Clearing the lowest set bit leaves zero only when a single bit was set
   always_comb begin
      any_o      = |vec_i;
      one_left_o = any_o && ((vec_i & (vec_i - 64'd1)) == 64'd0);
   end

endmodule

// File: rtl/movegen_collector.sv
// Sequencer for the move-propagation array: takes a request, strobes init,
// waits for the array to settle, captures movebit with pawn rules applied,
// streams the targets lowest square first and finishes with a done pulse.
module movegen_collector
   import chess_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 7
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [5:0]       req_square,
   input  logic [3:0]       req_piece,
   input  logic [63:0]      board_occ,
   output logic             init,
   output logic [5:0]       square_calc,
   output logic [3:0]       piece_type_calc,
   input  logic [63:0]      movebit,
   output logic             mv_valid,
   input  logic             mv_ready,
   output logic [5:0]       mv_to,
   output logic             mv_last,
   output logic             done,
   output logic [CNT_W-1:0] move_count
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] INIT    = 3'd1;
   localparam logic [2:0] SETTLE  = 3'd2;
   localparam logic [2:0] CAPTURE = 3'd3;
   localparam logic [2:0] EMIT    = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

   logic [2:0]       state_q, state_d;
   logic [SW-1:0]    settleCnt_q, settleCnt_d;
   logic [63:0]      mask_q, mask_d;
   logic [CNT_W-1:0] pendCount_q, pendCount_d;
   logic [CNT_W-1:0] moveCount_q, moveCount_d;
   logic [5:0]       square_q, square_d;
   logic [3:0]       piece_q, piece_d;

   logic [63:0]      capMask;
   logic [CNT_W-1:0] capCount;
   logic [5:0]       lsbIdx;
   logic             oneLeft;
   logic             maskAny;

   // Pawn target offsets, kept as 7-bit two's complement so that bit 6 of
   // origin+offset flags a target that falls off either end of the board
   logic             isWhite, isBlack, isPawn;
   logic [6:0]       offStraight, offLowFile, offHighFile, offDouble;
   logic [6:0]       tgtStraight, tgtLowFile, tgtHighFile, tgtDouble;
   logic [2:0]       startRank;

   lsb_finder64 uFinder (
      .vec_i      (mask_q),
      .idx_o      (lsbIdx),
      .one_left_o (oneLeft),
      .any_o      (maskAny)
   );

   // Select pawn direction and compute the candidate target squares
   always_comb begin
      isWhite     = (piece_q == WPAWN);
      isBlack     = (piece_q == BPAWN);
      isPawn      = isWhite || isBlack;
      offStraight = isWhite ? 7'd8  : 7'd120;
      offLowFile  = isWhite ? 7'd7  : 7'd119;
      offHighFile = isWhite ? 7'd9  : 7'd121;
      offDouble   = isWhite ? 7'd16 : 7'd112;
      startRank   = isWhite ? WHITE_PAWN_RANK : BLACK_PAWN_RANK;
      tgtStraight = {1'b0, square_q} + offStraight;
      tgtLowFile  = {1'b0, square_q} + offLowFile;
      tgtHighFile = {1'b0, square_q} + offHighFile;
      tgtDouble   = {1'b0, square_q} + offDouble;
   end

   // Apply the pawn rules the array does not know about, then drop the origin
   always_comb begin
      capMask = movebit;
      if (isPawn) begin
         if (!tgtStraight[6] && board_occ[tgtStraight[5:0]])
            capMask[tgtStraight[5:0]] = 1'b0;
         if (!tgtLowFile[6] && ((file(square_q) == 3'd0) || !board_occ[tgtLowFile[5:0]]))
            capMask[tgtLowFile[5:0]] = 1'b0;
         if (!tgtHighFile[6] && ((file(square_q) == 3'd7) || !board_occ[tgtHighFile[5:0]]))
            capMask[tgtHighFile[5:0]] = 1'b0;
         if ((rank(square_q) == startRank) && !tgtStraight[6] && capMask[tgtStraight[5:0]]
             && !tgtDouble[6] && !board_occ[tgtDouble[5:0]])
            capMask[tgtDouble[5:0]] = 1'b1;
      end
      capMask[square_q] = 1'b0;
      capCount = CNT_W'($countones(capMask));
   end

   // Sequencer next-state logic
   always_comb begin
      state_d     = state_q;
      settleCnt_d = settleCnt_q;
      mask_d      = mask_q;
      pendCount_d = pendCount_q;
      moveCount_d = moveCount_q;
      square_d    = square_q;
      piece_d     = piece_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               square_d = req_square;
               piece_d  = req_piece;
               state_d  = INIT;
            end
         end
         INIT: begin
            settleCnt_d = SETTLE_LOAD;
            state_d     = SETTLE;
         end
         SETTLE: begin
            if (settleCnt_q == '0) state_d = CAPTURE;
            else                   settleCnt_d = settleCnt_q - SW'(1);
         end
         CAPTURE: begin
            mask_d      = capMask;
            pendCount_d = capCount;
            if (capMask == 64'd0) begin
               moveCount_d = capCount;
               state_d     = DONE;
            end else begin
               state_d     = EMIT;
            end
         end
         EMIT: begin
            if (mv_ready && maskAny) begin
               mask_d[lsbIdx] = 1'b0;
               if (oneLeft) begin
                  moveCount_d = pendCount_q;
                  state_d     = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any request in flight
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         settleCnt_q <= '0;
         mask_q      <= '0;
         pendCount_q <= '0;
         moveCount_q <= '0;
         square_q    <= '0;
         piece_q     <= '0;
      end else begin
         state_q     <= state_d;
         settleCnt_q <= settleCnt_d;
         mask_q      <= mask_d;
         pendCount_q <= pendCount_d;
         moveCount_q <= moveCount_d;
         square_q    <= square_d;
         piece_q     <= piece_d;
      end
   end

   // Outputs decode directly from registered state
   always_comb begin
      req_ready       = (state_q == IDLE);
      init            = (state_q == INIT);
      done            = (state_q == DONE);
      mv_valid        = (state_q == EMIT) && maskAny;
      mv_to           = mv_valid ? lsbIdx : 6'd0;
      mv_last         = mv_valid && oneLeft;
      square_calc     = square_q;
      piece_type_calc = piece_q;
      move_count      = moveCount_q;
   end

endmodule

// File: tb/tb_movegen_collector.sv
// Testbench for movegen_collector: an array stand-in that only presents the
// real movebit pattern during the expected capture cycle, a coordinate-based
// model of the legal targets, and one per-cycle compare process.
module tb_movegen_collector;
   import chess_pkg::*;

   localparam int SETTLE = 4;
   localparam int CNT_W  = 7;
   localparam logic [63:0] JUNK = 64'hFFFF_FFFF_FFFF_FFFF;

   logic             clock;
   logic             reset_n;
   logic             req_valid;
   logic             req_ready;
   logic [5:0]       req_square;
   logic [3:0]       req_piece;
   logic [63:0]      board_occ;
   logic             init;
   logic [5:0]       square_calc;
   logic [3:0]       piece_type_calc;
   logic [63:0]      movebit;
   logic             mv_valid;
   logic             mv_ready;
   logic [5:0]       mv_to;
   logic             mv_last;
   logic             done;
   logic [CNT_W-1:0] move_count;

   int          compared = 0;
   int          mismatched = 0;
   int          expQ[$];
   int          expCount = 0;
   int          lastCount = 0;
   int          doneSeen = 0;
   int          beatsTaken = 0;
   int          initRun = 0;
   int          readyMode = 0;
   int          stallLeft = 0;
   int          sinceInit = 99;
   logic [63:0] arrayVal = '0;

   movegen_collector #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_square      (req_square),
      .req_piece       (req_piece),
      .board_occ       (board_occ),
      .init            (init),
      .square_calc     (square_calc),
      .piece_type_calc (piece_type_calc),
      .movebit         (movebit),
      .mv_valid        (mv_valid),
      .mv_ready        (mv_ready),
      .mv_to           (mv_to),
      .mv_last         (mv_last),
      .done            (done),
      .move_count      (move_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Array stand-in: the settled pattern is visible only in the capture cycle
   always @(negedge clock) begin
      if (!reset_n)        sinceInit <= 99;
      else if (init)       sinceInit <= 0;
      else if (sinceInit < 99) sinceInit <= sinceInit + 1;
   end
   assign movebit = (sinceInit == SETTLE + 1) ? arrayVal : JUNK;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Legal target set worked out on rank/file coordinates
   function automatic logic [63:0] modelMask(input int sq, input int pc,
                                             input logic [63:0] occ,
                                             input logic [63:0] mb);
      logic [63:0] m;
      int r, f, dir, fwd, start, idx, tf;
      m = mb;
      r = sq / 8;
      f = sq % 8;
      if (pc == int'(WPAWN) || pc == int'(BPAWN)) begin
         dir   = (pc == int'(WPAWN)) ? 1 : -1;
         start = (pc == int'(WPAWN)) ? 1 : 6;
         fwd   = sq + 8 * dir;
         if (fwd >= 0 && fwd < 64 && occ[fwd]) m[fwd] = 1'b0;
         for (int df = -1; df <= 1; df += 2) begin
            idx = sq + 8 * dir + df;
            tf  = f + df;
            if (idx >= 0 && idx < 64) begin
               if (tf < 0 || tf > 7 || !occ[idx]) m[idx] = 1'b0;
            end
         end
         if (r == start && m[fwd] && !occ[sq + 16 * dir]) m[sq + 16 * dir] = 1'b1;
      end
      m[sq] = 1'b0;
      return m;
   endfunction

   // Per-cycle comparison of the stream and completion against the model
   always @(negedge clock) begin
      if (reset_n) begin
         if (mv_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedBeat", 64'(mv_valid), 64'd0);
            end else begin
               checkOutput("mvTo", 64'(mv_to), 64'(expQ[0]));
               checkOutput("mvLast", 64'(mv_last), 64'(expQ.size() == 1));
               if (mv_ready) begin
                  void'(expQ.pop_front());
                  beatsTaken++;
               end
            end
         end
         if (done) begin
            checkOutput("moveCount", 64'(move_count), 64'(expCount));
            checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
            checkOutput("busyInDone", 64'(req_ready), 64'd0);
            doneSeen++;
         end
         if (init) initRun++;
         else if (initRun != 0) begin
            checkOutput("initWidth", 64'(initRun), 64'd1);
            initRun = 0;
         end
      end else begin
         initRun = 0;
      end
   end

   // Consumer ready: always, stalled 3 cycles after the first beat, or never
   initial begin
      mv_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         case (readyMode)
            1: begin
               if (beatsTaken == 1 && stallLeft > 0) begin
                  mv_ready = 1'b0;
                  stallLeft--;
               end else mv_ready = 1'b1;
            end
            2:       mv_ready = 1'b0;
            default: mv_ready = 1'b1;
         endcase
      end
   end

   // Issue one request, pin the model with a literal and wait for done
   task automatic applyStimulus(input int sq, input int pc, input logic [63:0] occ,
                                input logic [63:0] mb, input logic [63:0] litMask);
      logic [63:0] m;
      int startDone;
      m = modelMask(sq, pc, occ, mb);
      checkOutput("modelPin", m, litMask);
      expQ.delete();
      for (int i = 0; i < 64; i++) if (m[i]) expQ.push_back(i);
      expCount   = $countones(m);
      beatsTaken = 0;
      arrayVal   = mb;
      board_occ  = occ;
      @(posedge clock);
      #1;
      req_valid  = 1'b1;
      req_square = 6'(sq);
      req_piece  = 4'(pc);
      @(negedge clock);
      checkOutput("reqReadyIdle", 64'(req_ready), 64'd1);
      @(posedge clock);
      #1;
      req_valid  = 1'b0;
      req_square = '0;
      req_piece  = '0;
      @(negedge clock);
      checkOutput("initHigh", 64'(init), 64'd1);
      checkOutput("squareCalc", 64'(square_calc), 64'(sq));
      checkOutput("pieceCalc", 64'(piece_type_calc), 64'(pc));
      checkOutput("countHeld", 64'(move_count), 64'(lastCount));
      @(negedge clock);
      checkOutput("initLow", 64'(init), 64'd0);
      startDone = doneSeen;
      for (int c = 0; c < 200 && doneSeen == startDone; c++) @(negedge clock);
      if (doneSeen == startDone) checkOutput("doneTimeout", 64'd0, 64'd1);
      lastCount = expCount;
      @(negedge clock);
      checkOutput("readyAfterDone", 64'(req_ready), 64'd1);
      checkOutput("countAfterDone", 64'(move_count), 64'(lastCount));
   endtask

   initial begin
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_square = '0;
      req_piece  = '0;
      board_occ  = '0;
      #1;
      checkOutput("rstReqReady", 64'(req_ready), 64'd1);
      checkOutput("rstInit", 64'(init), 64'd0);
      checkOutput("rstValid", 64'(mv_valid), 64'd0);
      checkOutput("rstDone", 64'(done), 64'd0);
      checkOutput("rstCount", 64'(move_count), 64'd0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;

      // Rook on a1: straight up the first rank
      applyStimulus(0, int'(WROOK), 64'h1, 64'h1FE, 64'h1FE);
      // e2 pawn on empty board: diagonals dropped, double push added
      applyStimulus(12, int'(WPAWN), 64'h0, (64'd1 << 19) | (64'd1 << 20) | (64'd1 << 21),
                    (64'd1 << 20) | (64'd1 << 28));
      // a2 pawn: wrapped diagonal dropped, capture kept, double push
      applyStimulus(8, int'(WPAWN), 64'd1 << 17, (64'd1 << 15) | (64'd1 << 16) | (64'd1 << 17),
                    (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 24));
      // Black pawn blocked straight ahead: zero moves
      applyStimulus(52, int'(BPAWN), 64'd1 << 44, 64'd1 << 44, 64'd0);
      // Black pawn c7: capture kept, empty diagonal dropped, double push
      applyStimulus(50, int'(BPAWN), 64'd1 << 41, (64'd1 << 41) | (64'd1 << 42) | (64'd1 << 43),
                    (64'd1 << 34) | (64'd1 << 41) | (64'd1 << 42));
      // Black pawn h7: occupied but wrapping diagonal still dropped
      applyStimulus(55, int'(BPAWN), 64'd1 << 48, (64'd1 << 46) | (64'd1 << 47) | (64'd1 << 48),
                    (64'd1 << 39) | (64'd1 << 47));

      // Consumer stall mid-stream; origin bit from the array must be dropped
      readyMode = 1;
      stallLeft = 3;
      applyStimulus(27, int'(WQUEEN), 64'h0, 64'h0000_0000_F800_0000, 64'h0000_0000_F000_0000);
      checkOutput("stallApplied", 64'(stallLeft), 64'd0);
      readyMode = 0;

      // Reset while streaming abandons the request silently
      readyMode = 2;
      expQ.delete();
      for (int i = 1; i <= 8; i++) expQ.push_back(i);
      expCount  = 8;
      arrayVal  = 64'h1FE;
      board_occ = 64'h1;
      @(posedge clock);
      #1;
      req_valid  = 1'b1;
      req_square = 6'd0;
      req_piece  = WROOK;
      @(posedge clock);
      #1 req_valid = 1'b0;
      for (int c = 0; c < 50 && !mv_valid; c++) @(negedge clock);
      checkOutput("reachedEmit", 64'(mv_valid), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("abortValid", 64'(mv_valid), 64'd0);
      checkOutput("abortReady", 64'(req_ready), 64'd1);
      checkOutput("abortCount", 64'(move_count), 64'd0);
      checkOutput("abortSquare", 64'(square_calc), 64'd0);
      repeat (2) begin
         @(negedge clock);
         checkOutput("abortNoDone", 64'(done), 64'd0);
      end
      expQ.delete();
      readyMode = 0;
      lastCount = 0;
      @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      checkOutput("readyAfterReset", 64'(req_ready), 64'd1);
      applyStimulus(0, int'(WROOK), 64'h1, 64'h1FE, 64'h1FE);

      repeat (3) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
